// File: rtl/ahb_slave_if_gen_if.sv
// AHB-Lite side bundle of the bridge slave front-end: bus inputs, decode/pipeline
// outputs and the slave response signals.
interface ahb_slave_if_gen_if #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int NUM_SLV = 3,
  parameter int DEPTH   = 2
);
  logic                      Hwrite;
  logic                      Hreadyin;
  logic [1:0]                Htrans;
  logic [2:0]                Hsize;
  logic [ADDR_W-1:0]         Haddr;
  logic [DATA_W-1:0]         Hwdata;
  logic [DATA_W-1:0]         Prdata;
  logic                      bridge_stall;
  logic                      valid;
  logic [NUM_SLV-1:0]        tempselx;
  logic [DEPTH*ADDR_W-1:0]   Haddr_pipe;
  logic [DEPTH*DATA_W-1:0]   Hwdata_pipe;
  logic                      Hwritereg;
  logic                      Hreadyout;
  logic [1:0]                Hresp;
  logic [DATA_W-1:0]         Hrdata;
  logic [15:0]               err_count;

  modport slave (
    input  Hwrite, Hreadyin, Htrans, Hsize, Haddr, Hwdata, Prdata, bridge_stall,
    output valid, tempselx, Haddr_pipe, Hwdata_pipe, Hwritereg, Hreadyout, Hresp,
           Hrdata, err_count
  );

  modport master (
    output Hwrite, Hreadyin, Htrans, Hsize, Haddr, Hwdata, Prdata, bridge_stall,
    input  valid, tempselx, Haddr_pipe, Hwdata_pipe, Hwritereg, Hreadyout, Hresp,
           Hrdata, err_count
  );
endinterface

// File: rtl/ahb_slave_if_gen.sv
// AHB-Lite slave front-end of the AHB2APB bridge: region decode, transfer qualification,
// address/data pipelining and the two-cycle ERROR response with a saturating error count.
module ahb_slave_if_gen #(
  parameter int                ADDR_W        = 32,
  parameter int                DATA_W        = 32,
  parameter int                NUM_SLV       = 3,
  parameter logic [ADDR_W-1:0] BASE_ADDR     = 32'h8000_0000,
  parameter int                SLV_SIZE_LOG2 = 26,
  parameter int                DEPTH         = 2
) (
  input logic                  Hclk,
  input logic                  Hresetn,
  ahb_slave_if_gen_if.slave    bus
);

  localparam logic [2:0]        MAX_SIZE  = 3'($clog2(DATA_W/8));
  localparam logic [ADDR_W-1:0] SLV_COUNT = ADDR_W'(NUM_SLV);

  typedef enum logic [1:0] {ST_OKAY, ST_ERR1, ST_ERR2} state_e;

  state_e                  state;
  state_e                  state_next;
  logic [ADDR_W-1:0]       offset;
  logic [ADDR_W-1:0]       region_idx;
  logic [ADDR_W-1:0]       align_mask;
  logic                    in_range;
  logic                    active;
  logic                    bad;
  logic [NUM_SLV-1:0]      sel;
  logic                    readyout;
  logic [1:0]              resp;
  logic [15:0]             err_cnt;
  logic [DEPTH*ADDR_W-1:0] addr_pipe;
  logic [DEPTH*DATA_W-1:0] wdata_pipe;
  logic                    write_reg;

  // Addresses below the base never wrap into a region, hence the explicit >= test.
  always_comb begin
    offset     = bus.Haddr - BASE_ADDR;
    region_idx = offset >> SLV_SIZE_LOG2;
    in_range   = (bus.Haddr >= BASE_ADDR) && (region_idx < SLV_COUNT);
    align_mask = ~({ADDR_W{1'b1}} << bus.Hsize);
    active     = (bus.Htrans == 2'b10) || (bus.Htrans == 2'b11);
    bad        = active && bus.Hreadyin &&
                 (!in_range || (bus.Hsize > MAX_SIZE) || ((bus.Haddr & align_mask) != '0));
  end

  always_comb begin
    sel = '0;
    for (int i = 0; i < NUM_SLV; i++) begin
      sel[i] = Hresetn && in_range && (region_idx == ADDR_W'(i));
    end
  end

  assign bus.tempselx = sel;
  assign bus.valid    = Hresetn && bus.Hreadyin && active && !bad && (state == ST_OKAY);
  assign bus.Hrdata   = bus.Prdata;

  always_ff @(posedge Hclk or negedge Hresetn) begin
    if (!Hresetn) state <= ST_OKAY;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_OKAY: if (bad) state_next = ST_ERR1;
      ST_ERR1: state_next = ST_ERR2;
      ST_ERR2: state_next = bad ? ST_ERR1 : ST_OKAY;
      default: state_next = ST_OKAY;
    endcase
  end

  // Bridge back-pressure only shapes HREADYOUT while no error response is in flight.
  always_comb begin
    resp     = 2'b00;
    readyout = 1'b1;
    case (state)
      ST_OKAY: readyout = ~bus.bridge_stall;
      ST_ERR1: begin
        resp     = 2'b01;
        readyout = 1'b0;
      end
      ST_ERR2: begin
        resp     = 2'b01;
        readyout = 1'b1;
      end
      default: ;
    endcase
    if (!Hresetn) begin
      resp     = 2'b00;
      readyout = 1'b1;
    end
  end

  assign bus.Hresp     = resp;
  assign bus.Hreadyout = readyout;

  always_ff @(posedge Hclk or negedge Hresetn) begin
    if (!Hresetn) begin
      err_cnt <= '0;
    end else if ((state_next == ST_ERR1) && (state != ST_ERR1) && (err_cnt != 16'hFFFF)) begin
      err_cnt <= err_cnt + 16'd1;
    end
  end

  assign bus.err_count = err_cnt;

  // Stage 0 sits in the low slice and is the newest entry.
  always_ff @(posedge Hclk or negedge Hresetn) begin
    if (!Hresetn) begin
      addr_pipe  <= '0;
      wdata_pipe <= '0;
      write_reg  <= 1'b0;
    end else if (bus.Hreadyin) begin
      addr_pipe  <= {addr_pipe[(DEPTH-1)*ADDR_W-1:0], bus.Haddr};
      wdata_pipe <= {wdata_pipe[(DEPTH-1)*DATA_W-1:0], bus.Hwdata};
      write_reg  <= bus.Hwrite;
    end
  end

  assign bus.Haddr_pipe  = addr_pipe;
  assign bus.Hwdata_pipe = wdata_pipe;
  assign bus.Hwritereg   = write_reg;

endmodule

// File: tb/tb_ahb_slave_if_gen.sv
// Bench for ahb_slave_if_gen: directed scenarios then random traffic, every cycle
// compared against a transaction-level reference model.
module tb_ahb_slave_if_gen;

  localparam int          ADDR_W        = 32;
  localparam int          DATA_W        = 32;
  localparam int          NUM_SLV       = 3;
  localparam int          DEPTH         = 4;
  localparam int          SLV_SIZE_LOG2 = 26;
  localparam logic [31:0] BASE          = 32'h8000_0000;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;

  always #5 clk = ~clk;

  ahb_slave_if_gen_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .NUM_SLV(NUM_SLV), .DEPTH(DEPTH)) bus ();

  ahb_slave_if_gen #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .NUM_SLV(NUM_SLV), .BASE_ADDR(BASE),
    .SLV_SIZE_LOG2(SLV_SIZE_LOG2), .DEPTH(DEPTH)
  ) dut (
    .Hclk(clk),
    .Hresetn(rst_n),
    .bus(bus)
  );

  int checks   = 0;
  int failures = 0;

  logic        c_write, c_ready, c_stall;
  logic [1:0]  c_trans;
  logic [2:0]  c_size;
  logic [31:0] c_addr, c_wdata, c_prdata;

  // Reference model: remaining error-response cycles, error tally, pipeline contents.
  int          err_left;
  int unsigned err_total;
  logic [31:0] m_addr  [DEPTH];
  logic [31:0] m_wdata [DEPTH];
  logic        m_write;

  task automatic checkOutput(input string tag, input logic [127:0] observed, input logic [127:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
    end
  endtask

  function automatic int slot_of(input logic [31:0] a);
    longint unsigned off;
    if (a < BASE) return -1;
    off = 64'(a - BASE);
    if ((off / (64'd1 << SLV_SIZE_LOG2)) >= 64'(NUM_SLV)) return -1;
    return int'(off / (64'd1 << SLV_SIZE_LOG2));
  endfunction

  function automatic bit is_bad(input logic [1:0] tr, input logic [2:0] sz, input logic [31:0] a, input logic rdy);
    bit act;
    act = (tr >= 2'd2);
    return act && rdy && ((slot_of(a) < 0) || (sz > 3'd2) || ((a % (32'd1 << sz)) != 0));
  endfunction

  function automatic logic [127:0] packed_addr();
    logic [127:0] v = '0;
    for (int k = 0; k < DEPTH; k++) v[k*32 +: 32] = m_addr[k];
    return v;
  endfunction

  function automatic logic [127:0] packed_wdata();
    logic [127:0] v = '0;
    for (int k = 0; k < DEPTH; k++) v[k*32 +: 32] = m_wdata[k];
    return v;
  endfunction

  task automatic modelReset();
    err_left  = 0;
    err_total = 0;
    m_write   = 1'b0;
    for (int k = 0; k < DEPTH; k++) begin
      m_addr[k]  = '0;
      m_wdata[k] = '0;
    end
  endtask

  task automatic driveBus();
    bus.Hwrite       = c_write;
    bus.Htrans       = c_trans;
    bus.Hsize        = c_size;
    bus.Haddr        = c_addr;
    bus.Hwdata       = c_wdata;
    bus.Hreadyin     = c_ready;
    bus.bridge_stall = c_stall;
    bus.Prdata       = c_prdata;
  endtask

  task automatic setIdle();
    c_write = 1'b0; c_trans = 2'b00; c_size = 3'd0; c_addr = '0;
    c_wdata = '0;   c_ready = 1'b1;  c_stall = 1'b0; c_prdata = '0;
    driveBus();
  endtask

  task automatic checkAll();
    bit         bad;
    int         slot;
    logic [2:0] exp_sel;
    logic       exp_ready;
    bad       = is_bad(c_trans, c_size, c_addr, c_ready);
    slot      = slot_of(c_addr);
    exp_sel   = (slot >= 0) ? 3'(1 << slot) : 3'b000;
    exp_ready = (err_left == 2) ? 1'b0 : (err_left == 1) ? 1'b1 : !c_stall;
    checkOutput("valid", bus.valid, (c_ready && (c_trans >= 2'd2) && !bad && err_left == 0));
    checkOutput("tempselx", bus.tempselx, exp_sel);
    checkOutput("Hresp", bus.Hresp, (err_left > 0) ? 2'b01 : 2'b00);
    checkOutput("Hreadyout", bus.Hreadyout, exp_ready);
    checkOutput("Hrdata", bus.Hrdata, c_prdata);
    checkOutput("Haddr_pipe", bus.Haddr_pipe, packed_addr());
    checkOutput("Hwdata_pipe", bus.Hwdata_pipe, packed_wdata());
    checkOutput("Hwritereg", bus.Hwritereg, m_write);
    checkOutput("err_count", bus.err_count, 16'(err_total));
  endtask

  task automatic stepModel();
    bit bad;
    bad = is_bad(c_trans, c_size, c_addr, c_ready);
    if (err_left == 2) begin
      err_left = 1;
    end else if (bad) begin
      err_left = 2;
      if (err_total < 32'hFFFF) err_total++;
    end else begin
      err_left = 0;
    end
    if (c_ready) begin
      for (int k = DEPTH-1; k > 0; k--) begin
        m_addr[k]  = m_addr[k-1];
        m_wdata[k] = m_wdata[k-1];
      end
      m_addr[0]  = c_addr;
      m_wdata[0] = c_wdata;
      m_write    = c_write;
    end
  endtask

  task automatic applyStimulus(input logic wr, input logic [1:0] tr, input logic [2:0] sz,
                               input logic [31:0] a, input logic [31:0] wd,
                               input logic rdy, input logic stall);
    @(negedge clk);
    c_write = wr; c_trans = tr; c_size = sz; c_addr = a; c_wdata = wd;
    c_ready = rdy; c_stall = stall; c_prdata = $urandom;
    driveBus();
    #1;
    checkAll();
  endtask

  task automatic advanceClock();
    @(posedge clk);
    stepModel();
    #1;
  endtask

  function automatic logic [31:0] rand_addr();
    logic [31:0] off;
    off = $urandom & 32'h03FF_FFFF;
    if ($urandom_range(0, 3) != 0) off = off & ~32'h3;
    case ($urandom_range(0, 5))
      0:       return $urandom_range(0, 32'h7FFF_FFFF);
      1:       return BASE + off;
      2:       return BASE + 32'h0400_0000 + off;
      3:       return BASE + 32'h0800_0000 + off;
      4:       return BASE + 32'h0C00_0000 + off;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    logic [127:0] held;

    setIdle();
    modelReset();
    #1 rst_n = 1'b0;
    c_trans = 2'b10; c_size = 3'd2; c_addr = 32'h8000_0010;
    driveBus();
    #1;
    checkOutput("rst_valid", bus.valid, 1'b0);
    checkOutput("rst_tempselx", bus.tempselx, 3'b000);
    checkOutput("rst_Hreadyout", bus.Hreadyout, 1'b1);
    checkOutput("rst_Hresp", bus.Hresp, 2'b00);
    checkOutput("rst_err_count", bus.err_count, 16'h0);
    checkOutput("rst_Haddr_pipe", bus.Haddr_pipe, 128'h0);
    setIdle();
    @(negedge clk);
    rst_n = 1'b1;
    advanceClock();

    // Single write: decode, address capture, then data-phase write data capture.
    applyStimulus(1'b1, 2'b10, 3'd2, 32'h8000_0010, 32'h0, 1'b1, 1'b0);
    checkOutput("t1_valid", bus.valid, 1'b1);
    checkOutput("t1_tempselx", bus.tempselx, 3'b001);
    advanceClock();
    checkOutput("t1_stage0", bus.Haddr_pipe[31:0], 32'h8000_0010);
    checkOutput("t1_Hwritereg", bus.Hwritereg, 1'b1);
    applyStimulus(1'b0, 2'b00, 3'd0, 32'h0, 32'hA5A5_A5A5, 1'b1, 1'b0);
    advanceClock();
    checkOutput("t1_wdata_stage0", bus.Hwdata_pipe[31:0], 32'hA5A5_A5A5);

    // Reads across regions, the last one beyond slave 2.
    applyStimulus(1'b0, 2'b10, 3'd2, 32'h8400_0000, 32'h0, 1'b1, 1'b0);
    checkOutput("t2_sel1", bus.tempselx, 3'b010);
    advanceClock();
    applyStimulus(1'b0, 2'b10, 3'd2, 32'h8800_0004, 32'h0, 1'b1, 1'b0);
    checkOutput("t2_sel2", bus.tempselx, 3'b100);
    advanceClock();
    applyStimulus(1'b0, 2'b10, 3'd2, 32'h8C00_0000, 32'h0, 1'b1, 1'b0);
    checkOutput("t2_sel_none", bus.tempselx, 3'b000);
    checkOutput("t2_valid", bus.valid, 1'b0);
    advanceClock();
    applyStimulus(1'b0, 2'b00, 3'd0, 32'h0, 32'h0, 1'b1, 1'b0);
    checkOutput("t2_err1_resp", bus.Hresp, 2'b01);
    checkOutput("t2_err1_ready", bus.Hreadyout, 1'b0);
    advanceClock();
    applyStimulus(1'b0, 2'b00, 3'd0, 32'h0, 32'h0, 1'b1, 1'b0);
    checkOutput("t2_err2_resp", bus.Hresp, 2'b01);
    checkOutput("t2_err2_ready", bus.Hreadyout, 1'b1);
    advanceClock();
    applyStimulus(1'b0, 2'b00, 3'd0, 32'h0, 32'h0, 1'b1, 1'b0);
    checkOutput("t2_okay_resp", bus.Hresp, 2'b00);
    checkOutput("t2_err_count", bus.err_count, 16'd1);
    advanceClock();

    // Misaligned word access.
    applyStimulus(1'b0, 2'b10, 3'd2, 32'h8000_0002, 32'h0, 1'b1, 1'b0);
    checkOutput("t3_valid", bus.valid, 1'b0);
    advanceClock();
    applyStimulus(1'b0, 2'b00, 3'd0, 32'h0, 32'h0, 1'b1, 1'b0);
    checkOutput("t3_err1_ready", bus.Hreadyout, 1'b0);
    advanceClock();
    applyStimulus(1'b0, 2'b00, 3'd0, 32'h0, 32'h0, 1'b1, 1'b0);
    advanceClock();
    applyStimulus(1'b0, 2'b00, 3'd0, 32'h0, 32'h0, 1'b1, 1'b0);
    checkOutput("t3_err_count", bus.err_count, 16'd2);
    advanceClock();

    // Bridge stall with the bus holding: HREADYOUT low, pipes frozen.
    held = packed_addr();
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 2'b10, 3'd2, 32'h8000_1000 + 32'(i*4), $urandom, 1'b0, 1'b1);
      checkOutput("t4_ready", bus.Hreadyout, 1'b0);
      advanceClock();
      checkOutput("t4_hold", bus.Haddr_pipe, held);
    end

    // Four back-to-back transfers fill the whole pipeline.
    applyStimulus(1'b1, 2'b10, 3'd2, 32'h8000_0100, 32'h1111_1111, 1'b1, 1'b0);
    advanceClock();
    applyStimulus(1'b1, 2'b11, 3'd2, 32'h8400_0200, 32'h2222_2222, 1'b1, 1'b0);
    advanceClock();
    applyStimulus(1'b1, 2'b11, 3'd2, 32'h8800_0300, 32'h3333_3333, 1'b1, 1'b0);
    advanceClock();
    applyStimulus(1'b1, 2'b11, 3'd2, 32'h8000_0400, 32'h4444_4444, 1'b1, 1'b0);
    advanceClock();
    checkOutput("t6_stages", bus.Haddr_pipe,
                {32'h8000_0100, 32'h8400_0200, 32'h8800_0300, 32'h8000_0400});

    // Asynchronous reset landing in the first error cycle.
    applyStimulus(1'b0, 2'b10, 3'd2, 32'h9000_0000, 32'h0, 1'b1, 1'b0);
    advanceClock();
    #2 rst_n = 1'b0;
    c_addr = 32'h8000_0000;
    driveBus();
    #1;
    checkOutput("t5_ready", bus.Hreadyout, 1'b1);
    checkOutput("t5_resp", bus.Hresp, 2'b00);
    checkOutput("t5_err_count", bus.err_count, 16'h0);
    checkOutput("t5_pipe", bus.Haddr_pipe, 128'h0);
    checkOutput("t5_valid", bus.valid, 1'b0);
    checkOutput("t5_tempselx", bus.tempselx, 3'b000);
    modelReset();
    setIdle();
    @(negedge clk);
    rst_n = 1'b1;
    advanceClock();

    // Random traffic against the model.
    for (int i = 0; i < 800; i++) begin
      logic [2:0] sz;
      sz = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
      applyStimulus(1'($urandom), 2'($urandom), sz, rand_addr(), $urandom,
                    ($urandom_range(0, 4) != 0), ($urandom_range(0, 3) == 0));
      advanceClock();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
